// File: rtl/sc_argmax_decoder_pkg.sv
// Shared types and defaults for the stochastic argmax decoder.
// Holds the window/class defaults and the decoder state encoding.
package sc_argmax_decoder_pkg;

  localparam int SC_N2     = 10;
  localparam int SC_L_BITS = 10;
  localparam int SC_SKIP   = 2;
  localparam int SC_WIN    = 1 << SC_L_BITS;

  typedef logic [2:0] sc_argmax_state_t;

  localparam sc_argmax_state_t S_IDLE   = 3'd0;
  localparam sc_argmax_state_t S_SKIP   = 3'd1;
  localparam sc_argmax_state_t S_COUNT  = 3'd2;
  localparam sc_argmax_state_t S_ARGMAX = 3'd3;
  localparam sc_argmax_state_t S_DONE   = 3'd4;

endpackage

// File: rtl/sc_argmax_decoder_if.sv
// Host-side bundle of the argmax decoder: start/din in,
// busy/valid/result out.
interface sc_argmax_decoder_if
  import sc_argmax_decoder_pkg::*;
#(
  parameter int N2     = SC_N2,
  parameter int L_BITS = SC_L_BITS
);
  localparam int IDX_W = (N2 > 1) ? $clog2(N2) : 1;

  logic              start;
  logic [N2-1:0]     din;
  logic              busy;
  logic              valid;
  logic [IDX_W-1:0]  class_idx;
  logic [L_BITS:0]   max_count;

  modport master (
    output start, din,
    input  busy, valid, class_idx, max_count
  );

  modport slave (
    input  start, din,
    output busy, valid, class_idx, max_count
  );
endinterface

// File: rtl/sc_ones_counter.sv
// Per-class ones counter for one stochastic bitstream.
// Width L_BITS+1 so a full window of ones never wraps.
module sc_ones_counter
  import sc_argmax_decoder_pkg::*;
#(
  parameter int L_BITS = SC_L_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            bit_in,
  output logic [L_BITS:0] count
);
  logic [L_BITS:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && bit_in)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/sc_argmax_decoder.sv
// Counts ones per class over a fixed window, then runs a
// one-class-per-cycle argmax and reports the winner.
module sc_argmax_decoder
  import sc_argmax_decoder_pkg::*;
#(
  parameter int N2     = SC_N2,
  parameter int L_BITS = SC_L_BITS,
  parameter int SKIP   = SC_SKIP
) (
  input logic          clk,
  input logic          reset,
  sc_argmax_decoder_if.slave io
);
  localparam int IDX_W = (N2 > 1) ? $clog2(N2) : 1;
  localparam int CW    = L_BITS + 1;
  localparam int SW    = (SKIP > 1) ? $clog2(SKIP) : 1;

  sc_argmax_state_t state_q, state_d;
  logic [L_BITS-1:0] win_q, win_d;
  logic [SW-1:0]     skp_q, skp_d;
  logic [IDX_W-1:0]  arg_q, arg_d;
  logic [IDX_W-1:0]  bidx_q, bidx_d;
  logic [IDX_W-1:0]  cls_q, cls_d;
  logic [CW-1:0]     best_q, best_d;
  logic [CW-1:0]     max_q, max_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     cnt [N2];
  logic [CW-1:0]     cur;
  logic              clr, en;

  assign clr = (state_q == S_IDLE) && io.start;
  assign en  = (state_q == S_COUNT);

  for (genvar g = 0; g < N2; g++) begin : g_cnt
    sc_ones_counter #(.L_BITS(L_BITS)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .en     (en),
      .bit_in (io.din[g]),
      .count  (cnt[g])
    );
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < N2; i++)
      if (arg_q == IDX_W'(i)) cur = cnt[i];
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    skp_d   = skp_q;
    arg_d   = arg_q;
    bidx_d  = bidx_q;
    best_d  = best_q;
    cls_d   = cls_q;
    max_d   = max_q;
    valid_d = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (io.start) begin
          skp_d   = '0;
          win_d   = '0;
          state_d = (SKIP == 0) ? S_COUNT : S_SKIP;
        end
      end
      state_q == S_SKIP: begin
        if (skp_q == SW'(SKIP - 1))
          state_d = S_COUNT;
        else
          skp_d = skp_q + 1'b1;
      end
      state_q == S_COUNT: begin
        win_d = win_q + 1'b1;
        if (win_q == '1) begin
          arg_d   = '0;
          state_d = S_ARGMAX;
        end
      end
      state_q == S_ARGMAX: begin
        // Strict compare keeps the lowest index on ties
        if (arg_q == '0 || cur > best_q) begin
          best_d = cur;
          bidx_d = arg_q;
        end
        if (arg_q == IDX_W'(N2 - 1))
          state_d = S_DONE;
        else
          arg_d = arg_q + 1'b1;
      end
      state_q == S_DONE: begin
        cls_d   = bidx_q;
        max_d   = best_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      skp_q   <= '0;
      arg_q   <= '0;
      bidx_q  <= '0;
      best_q  <= '0;
      cls_q   <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      skp_q   <= skp_d;
      arg_q   <= arg_d;
      bidx_q  <= bidx_d;
      best_q  <= best_d;
      cls_q   <= cls_d;
      max_q   <= max_d;
      valid_q <= valid_d;
    end
  end

  assign io.busy      = (state_q != S_IDLE);
  assign io.valid     = valid_q;
  assign io.class_idx = cls_q;
  assign io.max_count = max_q;
endmodule
